mdu: RTL and testbench

//  Multiply/divide unit beside the ALU in the Execute stage of the 5-stage MIPS pipeline.

---
 rtl/mdu_pkg.sv | 55 +++++
 rtl/mdu.sv | 198 +++++++++++++++++++
 tb/tb_mdu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//
// Contents:
//   MDUOP_SIZE  width of the operation select bus
//   mdu_op_e    operation codes driven by the decoder into the MDU
//   mdu_state_e sequencer states (idle / running a multi-cycle op)
//   isLongOp    true for ops that occupy the unit for a fixed latency
//
// Build option: MDU_MADD_EN adds the multiply-accumulate family
// (MADD, MADDU, MSUB, MSUBU). Without it those encodings do not exist
// and the unit treats them like NONE.
package mdu_pkg;

  localparam int MDUOP_SIZE = 4;

  typedef enum logic [MDUOP_SIZE-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
`ifdef MDU_MADD_EN
    ,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
`endif
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that latch a result into the pending registers and then hold
  // busy for a fixed number of cycles before committing to HI/LO.
  function automatic logic isLongOp(input logic [MDUOP_SIZE-1:0] opCode);
    logic result;
    result = 1'b0;
    case (opCode)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: result = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: result = 1'b1;
`endif
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit sitting beside the ALU in the Execute stage.
// Owns the architectural HI/LO registers. Multiplies and divides compute
// their result in the start cycle into pending registers; a fixed
// countdown then models the latency and the result is committed to HI/LO
// when the countdown expires. mfhi/mflo are served combinationally.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   start      an MDU instruction is valid in E this cycle
//   op         operation select (mdu_op_e)
//   operand1   forwarded rs value
//   operand2   forwarded rt value
//   busy       a multi-cycle operation is in progress
//   read_data  HI for MFHI, LO for MFLO, otherwise 0
//
// Build option: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which
// accumulate into {HI,LO} using the multiply latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MDUOP_SIZE-1:0] op,
  input  logic [31:0]           operand1,
  input  logic [31:0]           operand2,
  output logic                  busy,
  output logic [31:0]           read_data
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  logic             busy_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pendHi_q;
  logic [31:0]      pendHi_d;
  logic [31:0]      pendLo_q;
  logic [31:0]      pendLo_d;
  logic             pendValid_q;
  logic             pendValid_d;
  logic [CNT_W-1:0] latency_d;

  logic             acceptLong;
  logic             signedMul;
  logic [63:0]      mulA;
  logic [63:0]      mulB;
  logic [63:0]      product;
  logic [63:0]      accum;
  logic             divZero;
  logic             divOverflow;
  logic [31:0]      uDivisor;
  logic [31:0]      sDivisor;
  logic [31:0]      uQuot;
  logic [31:0]      uRem;
  logic signed [31:0] sQuot;
  logic signed [31:0] sRem;

  // Datapath for the start cycle. Operands are extended to 64 bits so a
  // plain unsigned multiply yields the correct signed or unsigned product.
  // Divisors are forced to 1 when dividing by zero (the result is then
  // discarded) and for INT_MIN / -1, where dividing by 1 gives exactly the
  // wrapped quotient 0x80000000 with remainder 0 without a host overflow.
  always_comb begin
    signedMul = (op == MDU_MULT);
`ifdef MDU_MADD_EN
    signedMul = signedMul || (op == MDU_MADD) || (op == MDU_MSUB);
`endif
    mulA    = signedMul ? {{32{operand1[31]}}, operand1} : {32'd0, operand1};
    mulB    = signedMul ? {{32{operand2[31]}}, operand2} : {32'd0, operand2};
    product = mulA * mulB;
    accum   = {hi_q, lo_q};

    divZero     = (operand2 == 32'd0);
    divOverflow = (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
    uDivisor    = divZero ? 32'd1 : operand2;
    sDivisor    = (divZero || divOverflow) ? 32'd1 : operand2;
    uQuot       = operand1 / uDivisor;
    uRem        = operand1 % uDivisor;
    sQuot       = $signed(operand1) / $signed(sDivisor);
    sRem        = $signed(operand1) % $signed(sDivisor);
  end

  // Next values of the pending result registers. They only change when a
  // long op is accepted; a start seen while busy is ignored entirely.
  always_comb begin
    pendHi_d    = pendHi_q;
    pendLo_d    = pendLo_q;
    pendValid_d = pendValid_q;
    latency_d   = CNT_W'(MULT_CYCLES);
    acceptLong  = start && !busy_q && isLongOp(op);
    if (acceptLong) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pendHi_d    = product[63:32];
          pendLo_d    = product[31:0];
          pendValid_d = 1'b1;
        end
        MDU_DIV: begin
          pendHi_d    = sRem;
          pendLo_d    = sQuot;
          pendValid_d = !divZero;
          latency_d   = CNT_W'(DIV_CYCLES);
        end
        MDU_DIVU: begin
          pendHi_d    = uRem;
          pendLo_d    = uQuot;
          pendValid_d = !divZero;
          latency_d   = CNT_W'(DIV_CYCLES);
        end
`ifdef MDU_MADD_EN
        MDU_MADD, MDU_MADDU: begin
          {pendHi_d, pendLo_d} = accum + product;
          pendValid_d          = 1'b1;
        end
        MDU_MSUB, MDU_MSUBU: begin
          {pendHi_d, pendLo_d} = accum - product;
          pendValid_d          = 1'b1;
        end
`endif
        default: begin
          pendValid_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer: idle accepts a new op (or an mthi/mtlo write), run counts
  // the latency down and commits the pending result when it reaches 1.
  // Without MDU_MADD_EN the accumulate source is simply unused.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      count_q     <= '0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pendHi_q    <= 32'd0;
      pendLo_q    <= 32'd0;
      pendValid_q <= 1'b0;
    end else begin
      pendHi_q    <= pendHi_d;
      pendLo_q    <= pendLo_d;
      pendValid_q <= pendValid_d;
      case (state_q)
        ST_IDLE: begin
          if (acceptLong) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            count_q <= latency_d;
          end else if (start && (op == MDU_MTHI)) begin
            hi_q <= operand1;
          end else if (start && (op == MDU_MTLO)) begin
            lo_q <= operand1;
          end
        end
        ST_RUN: begin
          if (count_q == CNT_W'(1)) begin
            if (pendValid_q) begin
              hi_q <= pendHi_q;
              lo_q <= pendLo_q;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  // HI/LO reads go straight from the registers so mfhi/mflo complete in E.
  always_comb begin
    read_data = 32'd0;
    case (op)
      MDU_MFHI: read_data = hi_q;
      MDU_MFLO: read_data = lo_q;
      default:  read_data = 32'd0;
    endcase
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for the multiply/divide unit. Inputs change 1 ns after
// the rising edge and outputs are sampled before the next one.
module tb_mdu;
  import mdu_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [MDUOP_SIZE-1:0] op;
  logic [31:0]           operand1;
  logic [31:0]           operand2;
  logic                  busy;
  logic [31:0]           read_data;

  int testCount = 0;
  int failCount = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .busy     (busy),
    .read_data(read_data)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [MDUOP_SIZE-1:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    start    = s;
    op       = o;
    operand1 = a;
    operand2 = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads HI and LO through mfhi/mflo within the current cycle.
  task automatic checkHiLo(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(1'b0, MDU_MFHI, 32'd0, 32'd0);
    #1;
    checkOutput({tag, ".hi"}, read_data, expHi);
    op = MDU_MFLO;
    #1;
    checkOutput({tag, ".lo"}, read_data, expLo);
    op = MDU_NONE;
  endtask

  // Issues one long op, counts busy cycles (bounded), checks that HI is
  // still the old value on the first and last busy cycle, then checks HI/LO.
  task automatic runLongOp(input string tag, input logic [MDUOP_SIZE-1:0] o,
                           input logic [31:0] a, input logic [31:0] b, input int expCycles,
                           input logic [31:0] oldHi, input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCycles;
    applyStimulus(1'b1, o, a, b);
    #1;
    checkOutput({tag, ".rdZero"}, read_data, 32'd0);
    tick();
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    busyCycles = 0;
    while (busy === 1'b1 && busyCycles < 40) begin
      busyCycles++;
      if (busyCycles == 1 || busyCycles == expCycles) begin
        op = MDU_MFHI;
        #1;
        checkOutput({tag, ".oldHi"}, read_data, oldHi);
        op = MDU_NONE;
      end
      tick();
    end
    checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expCycles));
    checkHiLo(tag, expHi, expLo);
  endtask

  // Safety net in case the DUT or bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed results.
  initial begin
    int busyCycles;
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkHiLo("reset", 32'd0, 32'd0);

    runLongOp("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runLongOp("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFA);
    runLongOp("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runLongOp("divu",  MDU_DIVU,  32'd7,         32'd2, 10, 32'hFFFF_FFFF, 32'd1,         32'd3);
    runLongOp("divOvf", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd1, 32'd0,         32'h8000_0000);

    applyStimulus(1'b1, MDU_MTHI, 32'h1234_5678, 32'd0);
    tick();
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    checkOutput("mthi.busy", {31'd0, busy}, 32'd0);
    checkHiLo("mthi", 32'h1234_5678, 32'h8000_0000);

    applyStimulus(1'b1, MDU_MTHI, 32'h0000_000A, 32'd0);
    tick();
    applyStimulus(1'b1, MDU_MTLO, 32'h0000_000B, 32'd0);
    tick();
    checkHiLo("mtlo", 32'h0000_000A, 32'h0000_000B);

    runLongOp("divu0", MDU_DIVU, 32'd5, 32'd0, 10, 32'h0000_000A, 32'h0000_000A, 32'h0000_000B);

    // Starts issued while busy must be ignored and must not stretch busy.
    busyCycles = 0;
    applyStimulus(1'b1, MDU_MULT, 32'd2, 32'd3);
    tick();
    while (busy === 1'b1 && busyCycles < 40) begin
      busyCycles++;
      if (busyCycles == 2)
        applyStimulus(1'b1, MDU_MTHI, 32'h0000_DEAD, 32'd0);
      else if (busyCycles == 3)
        applyStimulus(1'b1, MDU_DIVU, 32'd100, 32'd3);
      else
        applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      tick();
    end
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    checkOutput("busyStart.cycles", 32'(busyCycles), 32'd5);
    checkHiLo("busyStart", 32'd0, 32'd6);

    // Reset in the third busy cycle abandons the multiply.
    applyStimulus(1'b1, MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    tick();
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("midReset.busyBefore", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
    checkHiLo("midReset", 32'd0, 32'd0);
    repeat (8) tick();
    checkOutput("midReset.lateBusy", {31'd0, busy}, 32'd0);
    checkHiLo("midReset.late", 32'd0, 32'd0);

`ifdef MDU_MADD_EN
    applyStimulus(1'b1, MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
    tick();
    runLongOp("madd",  MDU_MADD,  32'd1, 32'd1, 5, 32'd0, 32'd1, 32'd0);
    runLongOp("msubu", MDU_MSUBU, 32'd1, 32'd1, 5, 32'd1, 32'd0, 32'hFFFF_FFFF);
`else
    // Encoding 9 is not part of the base set and acts as NONE.
    applyStimulus(1'b1, 4'd9, 32'd1, 32'd1);
    #1;
    checkOutput("op9.read", read_data, 32'd0);
    tick();
    applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
    checkOutput("op9.busy", {31'd0, busy}, 32'd0);
    tick();
    checkHiLo("op9", 32'd0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
